vx_split_join_ctrl: RTL and testbench
=====================================

VX_SPLIT_JOIN_CTRL -- requirements
Module: VX_split_join_ctrl

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 4: threads per warp and thread-mask width.
REQ-002 SHALL have parameter PC_WIDTH, default 32: PC width.
REQ-003 SHALL have parameter STACK_WIDTH, default NUM_THREADS+PC_WIDTH: width of the stack entry {mask, pc}.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port req_valid_i / req_ready_o, in/out, 1/1: request handshake.
REQ-007 SHALL have port req_is_split_i, input, 1: 1 = split, 0 = join.
REQ-008 SHALL have port req_tmask_i, input, NUM_THREADS: current warp thread mask.
REQ-009 SHALL have port req_pred_i, input, NUM_THREADS: per-thread branch predicate (split only).
REQ-010 SHALL have port req_else_pc_i, input, PC_WIDTH: else-path PC (split only).
REQ-011 SHALL have ports stk_push_o, stk_pop_o, stk_pair_o, outputs, 1 each: stack controls.
REQ-012 SHALL have ports stk_q1_o and stk_q2_o, outputs, STACK_WIDTH each: stack write data.
REQ-013 SHALL have ports stk_d_i (input, STACK_WIDTH), stk_index_i, stk_empty_i and stk_full_i (inputs, 1 each): stack read data and status.
REQ-014 SHALL have port rsp_valid_o / rsp_ready_i, out/in, 1/1: response handshake.
REQ-015 SHALL have ports rsp_tmask_o (output, NUM_THREADS) and rsp_pc_o (output, PC_WIDTH): new mask and redirect PC.
REQ-016 SHALL have port rsp_pc_valid_o, output, 1: 1 = redirect the warp to rsp_pc_o.
REQ-017 SHALL have port err_o, output, 1: sticky error (overflow or underflow).

Function
REQ-018 SHALL implement FSM states IDLE, JREAD, JPOP, RESP.
REQ-019 In IDLE, req_ready_o SHALL be 1; in every other state it SHALL be 0.
REQ-020 SHALL compute then = tmask&pred and else = tmask&~pred.
REQ-021 A split SHALL be divergent iff then!=0 and else!=0.
REQ-022 On an accepted divergent split with !stk_full_i, SHALL pulse push for one cycle with pair=1, q1={tmask,0} and q2={else,else_pc}; the response SHALL be tmask=then, pc_valid=0.
REQ-023 On an accepted non-divergent split with !stk_full_i, SHALL pulse push with pair=0 and q1={tmask,0}; q2 is don't-care; the response SHALL be tmask=tmask, pc_valid=0.
REQ-024 A split SHALL go IDLE->RESP, with push asserted in the accept cycle (latency 1).
REQ-025 A split accepted while stk_full_i=1 SHALL not push, SHALL set err_o, and SHALL respond with tmask unchanged and pc_valid=0.
REQ-026 A join accepted while !stk_empty_i SHALL go IDLE->JREAD->JPOP->RESP.
REQ-027 In JPOP, SHALL register stk_d_i and stk_index_i and assert pop for exactly one cycle.
REQ-028 A join with index=0 (first half of a pair) SHALL respond with tmask=d.mask, pc=d.pc and pc_valid=1.
REQ-029 A join with index=1 (reconvergence) SHALL respond with tmask=d.mask and pc_valid=0.
REQ-030 A join accepted while stk_empty_i=1 SHALL not pop, SHALL set err_o, SHALL go IDLE->RESP, and SHALL respond with tmask unchanged and pc_valid=0.
REQ-031 In RESP, rsp_valid_o SHALL be 1 and all rsp_* SHALL be held stable until rsp_ready_i.
REQ-032 On rsp_ready_i in RESP, SHALL go RESP->IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-033 push and pop SHALL never be asserted in the same cycle.

Reset
REQ-034 While rst_ni=0 at a clock edge, SHALL enter IDLE and clear err_o and all registered response fields.
REQ-035 While in reset, rsp_valid_o, stk_push_o and stk_pop_o SHALL be 0.
REQ-036 A reset during JREAD or JPOP SHALL abandon the join with no pop issued after reset.

Configuration
REQ-037 With SPLIT_JOIN_PERF_EN defined, SHALL expose 32-bit outputs perf_splits_o, perf_div_o and perf_joins_o.
REQ-038 Each counter SHALL increment once per accepted split, divergent split, and accepted join respectively, SHALL wrap modulo 2^32, and SHALL clear on reset.
REQ-039 Without SPLIT_JOIN_PERF_EN, those ports and counters SHALL be absent.

Structure
REQ-040 VX_split_join_pkg SHALL hold the FSM state enum and the sj_entry_t struct {mask, pc}.
REQ-041 The block SHALL contain no sub-module; the stack is instantiated by the parent and connected through the stk_* ports.

Verification
REQ-042 Scenario: split with tmask=1111, pred=0011, else_pc=0x100 -> push, pair=1, q2={1100,0x100}, q1={1111,0}, rsp tmask=0011 one cycle later.
REQ-043 Scenario: split with pred=1111 -> push, pair=0, rsp tmask=1111, pc_valid=0.
REQ-044 Scenario: join with index=0, d={1100,0x100} -> pop in JPOP, rsp tmask=1100, pc=0x100, pc_valid=1, rsp at 3rd cycle after accept.
REQ-045 Scenario: join with index=1, d={1111,0} -> rsp tmask=1111, pc_valid=0.
REQ-046 Scenario: join with stk_empty_i=1 -> no pop, err_o=1, rsp tmask=input tmask.
REQ-047 Scenario: rsp_ready_i held low 5 cycles -> rsp fields stable, req_ready_o=0; reset asserted in JREAD -> IDLE, no pop.

Source files
------------

// File: rtl/vx_split_join_pkg.sv
// Shared types for the warp split/join controller: FSM state encoding and
// the {mask, pc} divergence-stack entry at default widths.
package vx_split_join_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    JREAD = 2'd1,
    JPOP  = 2'd2,
    RESP  = 2'd3
  } sj_state_e;

  localparam int SJ_NUM_THREADS = 4;
  localparam int SJ_PC_WIDTH    = 32;

  typedef struct packed {
    logic [SJ_NUM_THREADS-1:0] mask;
    logic [SJ_PC_WIDTH-1:0]    pc;
  } sj_entry_t;

endpackage

// File: rtl/vx_split_join_ctrl.sv
// Warp split/join controller driving an external IPDOM stack through stk_*.
// Optional perf counters are built when SPLIT_JOIN_PERF_EN is defined.
module vx_split_join_ctrl
  import vx_split_join_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH    = 32,
  parameter int STACK_WIDTH = NUM_THREADS + PC_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_is_split_i,
  input  logic [NUM_THREADS-1:0] req_tmask_i,
  input  logic [NUM_THREADS-1:0] req_pred_i,
  input  logic [PC_WIDTH-1:0]    req_else_pc_i,
  output logic                   stk_push_o,
  output logic                   stk_pop_o,
  output logic                   stk_pair_o,
  output logic [STACK_WIDTH-1:0] stk_q1_o,
  output logic [STACK_WIDTH-1:0] stk_q2_o,
  input  logic [STACK_WIDTH-1:0] stk_d_i,
  input  logic                   stk_index_i,
  input  logic                   stk_empty_i,
  input  logic                   stk_full_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [NUM_THREADS-1:0] rsp_tmask_o,
  output logic [PC_WIDTH-1:0]    rsp_pc_o,
  output logic                   rsp_pc_valid_o,
  output logic                   err_o
`ifdef SPLIT_JOIN_PERF_EN
  ,
  output logic [31:0]            perf_splits_o,
  output logic [31:0]            perf_div_o,
  output logic [31:0]            perf_joins_o
`endif
);

  sj_state_e              state;
  logic [NUM_THREADS-1:0] then_mask;
  logic [NUM_THREADS-1:0] else_mask;
  logic                   divergent;
  logic                   accept;
  logic [NUM_THREADS-1:0] d_mask;
  logic [PC_WIDTH-1:0]    d_pc;
  logic [NUM_THREADS-1:0] rsp_tmask_q;
  logic [PC_WIDTH-1:0]    rsp_pc_q;
  logic                   rsp_pc_valid_q;
  logic                   err_q;

  assign then_mask = req_tmask_i & req_pred_i;
  assign else_mask = req_tmask_i & ~req_pred_i;
  assign divergent = (|then_mask) & (|else_mask);
  assign accept    = req_valid_i & (state == IDLE);

  assign d_mask = stk_d_i[STACK_WIDTH-1 -: NUM_THREADS];
  assign d_pc   = stk_d_i[PC_WIDTH-1:0];

  // Stack strobes are gated by rst_ni so nothing reaches the stack during reset.
  assign stk_push_o = rst_ni & accept & req_is_split_i & ~stk_full_i;
  assign stk_pair_o = stk_push_o & divergent;
  assign stk_pop_o  = rst_ni & (state == JPOP);
  assign stk_q1_o   = {req_tmask_i, {PC_WIDTH{1'b0}}};
  assign stk_q2_o   = {else_mask, req_else_pc_i};

  assign req_ready_o    = (state == IDLE);
  assign rsp_valid_o    = rst_ni & (state == RESP);
  assign rsp_tmask_o    = rsp_tmask_q;
  assign rsp_pc_o       = rsp_pc_q;
  assign rsp_pc_valid_o = rsp_pc_valid_q;
  assign err_o          = err_q;

  // Control FSM with registered response fields and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= IDLE;
      rsp_tmask_q    <= '0;
      rsp_pc_q       <= '0;
      rsp_pc_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            if (req_is_split_i) begin
              rsp_pc_q       <= '0;
              rsp_pc_valid_q <= 1'b0;
              state          <= RESP;
              if (stk_full_i) begin
                err_q       <= 1'b1;
                rsp_tmask_q <= req_tmask_i;
              end else begin
                rsp_tmask_q <= divergent ? then_mask : req_tmask_i;
              end
            end else if (stk_empty_i) begin
              err_q          <= 1'b1;
              rsp_tmask_q    <= req_tmask_i;
              rsp_pc_q       <= '0;
              rsp_pc_valid_q <= 1'b0;
              state          <= RESP;
            end else begin
              state <= JREAD;
            end
          end
        end
        JREAD: state <= JPOP;
        // Index 0 is the pending else-half of a pair, so the warp is redirected.
        JPOP: begin
          rsp_tmask_q    <= d_mask;
          rsp_pc_q       <= d_pc;
          rsp_pc_valid_q <= ~stk_index_i;
          state          <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPLIT_JOIN_PERF_EN
  logic [31:0] splits_q;
  logic [31:0] div_q;
  logic [31:0] joins_q;

  // Event counters, wrapping naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      splits_q <= 32'd0;
      div_q    <= 32'd0;
      joins_q  <= 32'd0;
    end else if (accept) begin
      if (req_is_split_i) begin
        splits_q <= splits_q + 32'd1;
        if (divergent) begin
          div_q <= div_q + 32'd1;
        end
      end else begin
        joins_q <= joins_q + 32'd1;
      end
    end
  end

  assign perf_splits_o = splits_q;
  assign perf_div_o    = div_q;
  assign perf_joins_o  = joins_q;
`endif

endmodule

// File: tb/tb_vx_split_join_ctrl.sv
// Self-checking bench for vx_split_join_ctrl: directed scenarios plus random
// transactions compared against a transaction-level reference model.
module tb_vx_split_join_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_is_split_i;
  logic [3:0]  req_tmask_i, req_pred_i;
  logic [31:0] req_else_pc_i;
  logic        stk_push_o, stk_pop_o, stk_pair_o;
  logic [35:0] stk_q1_o, stk_q2_o, stk_d_i;
  logic        stk_index_i, stk_empty_i, stk_full_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [3:0]  rsp_tmask_o;
  logic [31:0] rsp_pc_o;
  logic        rsp_pc_valid_o, err_o;

  int checks = 0;
  int errors = 0;
  bit err_model = 1'b0;

  vx_split_join_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_is_split_i(req_is_split_i), .req_tmask_i(req_tmask_i),
    .req_pred_i(req_pred_i), .req_else_pc_i(req_else_pc_i),
    .stk_push_o(stk_push_o), .stk_pop_o(stk_pop_o), .stk_pair_o(stk_pair_o),
    .stk_q1_o(stk_q1_o), .stk_q2_o(stk_q2_o), .stk_d_i(stk_d_i),
    .stk_index_i(stk_index_i), .stk_empty_i(stk_empty_i), .stk_full_i(stk_full_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_tmask_o(rsp_tmask_o), .rsp_pc_o(rsp_pc_o),
    .rsp_pc_valid_o(rsp_pc_valid_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          push;
    bit          pair;
    logic [35:0] q1;
    logic [35:0] q2;
    int          pops;
    int          latency;
    logic [3:0]  tmask;
    logic [31:0] pc;
    bit          pcv;
    bit          err;
  } exp_t;

  typedef struct {
    logic        push_acc;
    logic        pair_acc;
    logic [35:0] q1;
    logic [35:0] q2;
    int          pushes;
    int          pops;
    int          pop_cycle;
    int          latency;
    logic [3:0]  tmask;
    logic [31:0] pc;
    logic        pcv;
    int          unstable;
    int          overlap;
    int          ready_busy;
    logic        ready_acc;
    logic        ready_after;
  } obs_t;

  // Transaction-level expectation derived from the split/join rules.
  function automatic exp_t ref_model(bit is_split, logic [3:0] tm, logic [3:0] pr,
                                     logic [31:0] epc, logic [3:0] dm, logic [31:0] dpc,
                                     bit idx, bit empty, bit full);
    exp_t e;
    bit   div;
    e = '{default: 0};
    div = ($countones(tm & pr) != 0) && ($countones(tm & ~pr) != 0);
    if (is_split) begin
      e.latency = 1;
      e.push    = !full;
      e.pair    = !full && div;
      e.q1      = {tm, 32'h0};
      e.q2      = {tm & ~pr, epc};
      e.tmask   = (!full && div) ? (tm & pr) : tm;
      e.err     = full;
    end else if (empty) begin
      e.latency = 1;
      e.tmask   = tm;
      e.err     = 1'b1;
    end else begin
      e.latency = 3;
      e.pops    = 1;
      e.tmask   = dm;
      e.pcv     = !idx;
      e.pc      = dpc;
    end
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    err_model = 1'b0;
  endtask

  task automatic run_txn(input bit is_split, input logic [3:0] tm, input logic [3:0] pr,
                         input logic [31:0] epc, input logic [3:0] dm, input logic [31:0] dpc,
                         input bit idx, input bit empty, input bit full,
                         input int stall, input bit poke, output obs_t o);
    int cyc;
    o = '{default: 0};
    o.latency = -1;
    o.pop_cycle = -1;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_is_split_i = is_split; req_tmask_i = tm; req_pred_i = pr;
    req_else_pc_i = epc; stk_d_i = {dm, dpc}; stk_index_i = idx;
    stk_empty_i = empty; stk_full_i = full;
    #1;
    o.ready_acc = req_ready_o; o.push_acc = stk_push_o; o.pair_acc = stk_pair_o;
    o.q1 = stk_q1_o; o.q2 = stk_q2_o;
    o.pushes += int'(stk_push_o); o.pops += int'(stk_pop_o);
    if (stk_push_o && stk_pop_o) o.overlap++;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    cyc = 0;
    while (o.latency < 0 && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
      o.pushes += int'(stk_push_o); o.pops += int'(stk_pop_o);
      if (stk_push_o && stk_pop_o) o.overlap++;
      if (stk_pop_o) o.pop_cycle = cyc;
      if (req_ready_o) o.ready_busy++;
      if (rsp_valid_o) begin
        o.latency = cyc; o.tmask = rsp_tmask_o; o.pc = rsp_pc_o; o.pcv = rsp_pc_valid_o;
      end
    end
    if (o.latency < 0) return;
    if (poke) req_valid_i = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk_i);
      o.pushes += int'(stk_push_o); o.pops += int'(stk_pop_o);
      if (req_ready_o) o.ready_busy++;
      if (!rsp_valid_o || rsp_tmask_o !== o.tmask || rsp_pc_o !== o.pc ||
          rsp_pc_valid_o !== o.pcv) o.unstable++;
    end
    rsp_ready_i = 1'b1;
    #1;
    if (req_ready_o) o.ready_busy++;
    if (stk_push_o) o.pushes++;
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    o.pushes += int'(stk_push_o); o.pops += int'(stk_pop_o);
    if (rsp_valid_o) o.unstable++;
    o.ready_after = req_ready_o;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; req_valid_i = 1'b1; req_is_split_i = 1'b1;
    req_tmask_i = 4'b1111; req_pred_i = 4'b0011; stk_full_i = 1'b0; stk_empty_i = 1'b0;
    #1;
    checks++; if (stk_push_o !== 1'b0) begin errors++; $display("FAIL reset_push: got %b want 0", stk_push_o); end
    @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
    checks++; if (stk_pop_o !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", stk_pop_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    checks++; if (rsp_tmask_o !== 4'b0000 || rsp_pc_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_fields: got tmask %b pcv %b want 0000 0", rsp_tmask_o, rsp_pc_valid_o);
    end
    req_valid_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
  endtask

  task automatic test_split();
    obs_t o;
    run_txn(1'b1, 4'b1111, 4'b0011, 32'h100, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, o);
    checks++; if (o.push_acc !== 1'b1 || o.pair_acc !== 1'b1) begin
      errors++; $display("FAIL split_div_push: got push %b pair %b want 1 1", o.push_acc, o.pair_acc);
    end
    checks++; if (o.q1 !== {4'b1111, 32'h0}) begin errors++; $display("FAIL split_div_q1: got %h want f00000000", o.q1); end
    checks++; if (o.q2 !== {4'b1100, 32'h100}) begin errors++; $display("FAIL split_div_q2: got %h want c00000100", o.q2); end
    checks++; if (o.latency !== 1 || o.tmask !== 4'b0011 || o.pcv !== 1'b0) begin
      errors++; $display("FAIL split_div_rsp: got lat %0d tmask %b pcv %b want 1 0011 0", o.latency, o.tmask, o.pcv);
    end
    checks++; if (o.pushes !== 1 || o.pops !== 0) begin
      errors++; $display("FAIL split_div_counts: got pushes %0d pops %0d want 1 0", o.pushes, o.pops);
    end
    run_txn(1'b1, 4'b1111, 4'b1111, 32'h200, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, o);
    checks++; if (o.push_acc !== 1'b1 || o.pair_acc !== 1'b0) begin
      errors++; $display("FAIL split_uni_push: got push %b pair %b want 1 0", o.push_acc, o.pair_acc);
    end
    checks++; if (o.tmask !== 4'b1111 || o.pcv !== 1'b0) begin
      errors++; $display("FAIL split_uni_rsp: got tmask %b pcv %b want 1111 0", o.tmask, o.pcv);
    end
  endtask

  task automatic test_join();
    obs_t o;
    run_txn(1'b0, 4'b0011, 4'b0000, 32'h0, 4'b1100, 32'h100, 1'b0, 1'b0, 1'b0, 0, 1'b0, o);
    checks++; if (o.pops !== 1 || o.pop_cycle !== 2 || o.pushes !== 0) begin
      errors++; $display("FAIL join0_pop: got pops %0d at %0d pushes %0d want 1 at 2, 0", o.pops, o.pop_cycle, o.pushes);
    end
    checks++; if (o.latency !== 3) begin errors++; $display("FAIL join0_latency: got %0d want 3", o.latency); end
    checks++; if (o.tmask !== 4'b1100 || o.pc !== 32'h100 || o.pcv !== 1'b1) begin
      errors++; $display("FAIL join0_rsp: got %b %h %b want 1100 100 1", o.tmask, o.pc, o.pcv);
    end
    run_txn(1'b0, 4'b1100, 4'b0000, 32'h0, 4'b1111, 32'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0, o);
    checks++; if (o.tmask !== 4'b1111 || o.pcv !== 1'b0 || o.pops !== 1) begin
      errors++; $display("FAIL join1_rsp: got tmask %b pcv %b pops %0d want 1111 0 1", o.tmask, o.pcv, o.pops);
    end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL join_err_clear: got %b want 0", err_o); end
  endtask

  task automatic test_join_empty();
    obs_t o;
    run_txn(1'b0, 4'b0110, 4'b0000, 32'h0, 4'b1111, 32'h55, 1'b0, 1'b1, 1'b0, 0, 1'b0, o);
    checks++; if (o.pops !== 0) begin errors++; $display("FAIL join_empty_pop: got %0d want 0", o.pops); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL join_empty_err: got %b want 1", err_o); end
    checks++; if (o.latency !== 1 || o.tmask !== 4'b0110 || o.pcv !== 1'b0) begin
      errors++; $display("FAIL join_empty_rsp: got lat %0d tmask %b pcv %b want 1 0110 0", o.latency, o.tmask, o.pcv);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    run_txn(1'b1, 4'b1111, 4'b0101, 32'h2a, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5, 1'b1, o);
    checks++; if (o.unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", o.unstable); end
    checks++; if (o.ready_busy !== 0) begin errors++; $display("FAIL bp_ready_low: got %0d busy-ready cycles want 0", o.ready_busy); end
    checks++; if (o.pushes !== 1) begin errors++; $display("FAIL bp_no_accept: got %0d pushes want 1", o.pushes); end
    checks++; if (o.tmask !== 4'b0101 || o.ready_after !== 1'b1) begin
      errors++; $display("FAIL bp_rsp: got tmask %b ready_after %b want 0101 1", o.tmask, o.ready_after);
    end
  endtask

  task automatic test_reset_in_jread();
    int pops;
    pops = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_is_split_i = 1'b0; req_tmask_i = 4'b1010;
    stk_d_i = {4'b0101, 32'h44}; stk_index_i = 1'b0; stk_empty_i = 1'b0; stk_full_i = 1'b0;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (req_ready_o !== 1'b0 || stk_pop_o !== 1'b0) begin
      errors++; $display("FAIL jread_state: got ready %b pop %b want 0 0", req_ready_o, stk_pop_o);
    end
    rst_ni = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 pops += int'(stk_pop_o);
      @(negedge clk_i);
    end
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 pops += int'(stk_pop_o) + int'(rsp_valid_o);
      @(negedge clk_i);
    end
    checks++; if (pops !== 0) begin errors++; $display("FAIL jread_reset_pop: got %0d pop/rsp cycles want 0", pops); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL jread_reset_idle: got ready %b want 1", req_ready_o); end
    err_model = 1'b0;
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    bit is_split, idx, empty, full;
    logic [3:0] tm, pr, dm;
    logic [31:0] epc, dpc;
    int stall;
    for (int n = 0; n < 40; n++) begin
      is_split = 1'($urandom_range(0, 1));
      tm = 4'($urandom); pr = 4'($urandom); dm = 4'($urandom);
      epc = $urandom; dpc = $urandom; idx = 1'($urandom_range(0, 1));
      empty = ($urandom_range(0, 3) == 0); full = ($urandom_range(0, 3) == 0);
      stall = int'($urandom_range(0, 3));
      e = ref_model(is_split, tm, pr, epc, dm, dpc, idx, empty, full);
      run_txn(is_split, tm, pr, epc, dm, dpc, idx, empty, full, stall, 1'b0, o);
      if (e.err) err_model = 1'b1;
      checks++; if (o.ready_acc !== 1'b1 || o.push_acc !== e.push || o.pushes !== int'(e.push)) begin
        errors++; $display("FAIL rnd%0d_push: got %b/%0d want %b", n, o.push_acc, o.pushes, e.push);
      end
      if (e.push) begin
        checks++; if (o.pair_acc !== e.pair || o.q1 !== e.q1) begin
          errors++; $display("FAIL rnd%0d_pair_q1: got %b %h want %b %h", n, o.pair_acc, o.q1, e.pair, e.q1);
        end
      end
      if (e.pair) begin
        checks++; if (o.q2 !== e.q2) begin errors++; $display("FAIL rnd%0d_q2: got %h want %h", n, o.q2, e.q2); end
      end
      checks++; if (o.pops !== e.pops || (e.pops == 1 && o.pop_cycle !== 2)) begin
        errors++; $display("FAIL rnd%0d_pop: got %0d at %0d want %0d", n, o.pops, o.pop_cycle, e.pops);
      end
      checks++; if (o.latency !== e.latency) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, o.latency, e.latency); end
      checks++; if (o.tmask !== e.tmask || o.pcv !== e.pcv || (e.pcv && o.pc !== e.pc)) begin
        errors++; $display("FAIL rnd%0d_rsp: got %b %b %h want %b %b %h", n, o.tmask, o.pcv, o.pc, e.tmask, e.pcv, e.pc);
      end
      checks++; if (err_o !== err_model) begin errors++; $display("FAIL rnd%0d_err: got %b want %b", n, err_o, err_model); end
      checks++; if (o.overlap !== 0 || o.unstable !== 0 || o.ready_busy !== 0) begin
        errors++; $display("FAIL rnd%0d_protocol: got overlap %0d unstable %0d busy %0d want 0", n, o.overlap, o.unstable, o.ready_busy);
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; req_is_split_i = 1'b0; req_tmask_i = 4'h0;
    req_pred_i = 4'h0; req_else_pc_i = 32'h0; stk_d_i = 36'h0; stk_index_i = 1'b0;
    stk_empty_i = 1'b0; stk_full_i = 1'b0; rsp_ready_i = 1'b0;
    test_reset();
    test_split();
    test_join();
    test_join_empty();
    do_reset();
    test_backpressure();
    test_reset_in_jread();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
